// File: rtl/fw_rv_skid_buffer.sv
// Two-entry ready/valid register slice: every output, i_ready included, comes
// straight from a flop so neither the ready nor the valid/data path is combinational.
module fw_rv_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [1:0]       level
);

  // state | meaning
  // EMPTY | nothing held, o_valid low
  // BUSY  | main holds the head beat
  // FULL  | main holds the head beat, skid holds the next one; i_ready low
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_reg;
  logic [WIDTH-1:0] skid_reg;

  assign o_dat = main_reg;

  // Derived outputs are loaded together with the next state so they stay registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      main_reg <= '0;
      skid_reg <= '0;
      o_valid  <= 1'b0;
      i_ready  <= 1'b1;
      level    <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (i_valid) begin
            state    <= BUSY;
            main_reg <= i_dat;
            o_valid  <= 1'b1;
            i_ready  <= 1'b1;
            level    <= 2'd1;
          end
        end
        BUSY: begin
          if (i_valid && o_ready) begin
            main_reg <= i_dat;
          end else if (i_valid) begin
            state    <= FULL;
            skid_reg <= i_dat;
            i_ready  <= 1'b0;
            level    <= 2'd2;
          end else if (o_ready) begin
            state    <= EMPTY;
            o_valid  <= 1'b0;
            level    <= 2'd0;
          end
        end
        FULL: begin
          if (o_ready) begin
            state    <= BUSY;
            main_reg <= skid_reg;
            i_ready  <= 1'b1;
            level    <= 2'd1;
          end
        end
        default: begin
          state    <= EMPTY;
          o_valid  <= 1'b0;
          i_ready  <= 1'b1;
          level    <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fw_rv_skid_buffer.sv
// Directed vector table, streaming, random scoreboard, mid-operation reset
// and 32-bit width checks for fw_rv_skid_buffer.
module tb_fw_rv_skid_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  i_dat;
  logic        i_valid;
  logic        i_ready;
  logic [7:0]  o_dat;
  logic        o_valid;
  logic        o_ready;
  logic [1:0]  level;

  logic [31:0] w_i_dat;
  logic        w_i_valid;
  logic        w_i_ready;
  logic [31:0] w_o_dat;
  logic        w_o_valid;
  logic        w_o_ready;
  logic [1:0]  w_level;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  fw_rv_skid_buffer #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .i_dat(i_dat), .i_valid(i_valid), .i_ready(i_ready),
    .o_dat(o_dat), .o_valid(o_valid), .o_ready(o_ready), .level(level)
  );

  fw_rv_skid_buffer #(.WIDTH(32)) dut_w32 (
    .clock(clock), .reset(reset), .i_dat(w_i_dat), .i_valid(w_i_valid), .i_ready(w_i_ready),
    .o_dat(w_o_dat), .o_valid(w_o_valid), .o_ready(w_o_ready), .level(w_level)
  );

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_ir;
    logic [1:0] e_lv;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_ov, input logic [7:0] e_od,
                            input logic e_ir, input logic [1:0] e_lv);
    check({tag, " o_valid"}, 32'(o_valid), 32'(e_ov));
    check({tag, " o_dat"},   32'(o_dat),   32'(e_od));
    check({tag, " i_ready"}, 32'(i_ready), 32'(e_ir));
    check({tag, " level"},   32'(level),   32'(e_lv));
  endtask

  logic [7:0] sb[$];
  int         accepted;
  int         cycles;
  logic       iv_r, or_r, acc, del, stalled;
  logic [7:0] d_r, prev_dat;

  initial begin
    // inputs, then expected outputs after the following rising edge
    vecs[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0};
    vecs[1] = '{1'b1, 8'hA1, 1'b1, 1'b1, 8'hA1, 1'b1, 2'd1};
    vecs[2] = '{1'b1, 8'hA2, 1'b0, 1'b1, 8'hA1, 1'b0, 2'd2};
    vecs[3] = '{1'b1, 8'hA3, 1'b0, 1'b1, 8'hA1, 1'b0, 2'd2};
    vecs[4] = '{1'b1, 8'hA3, 1'b1, 1'b1, 8'hA2, 1'b1, 2'd1};
    vecs[5] = '{1'b1, 8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1, 2'd1};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA3, 1'b1, 2'd1};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA3, 1'b1, 2'd0};
    vecs[8] = '{1'b1, 8'hB4, 1'b0, 1'b1, 8'hB4, 1'b1, 2'd1};
    vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hB4, 1'b1, 2'd0};

    reset = 1'b1;
    i_valid = 1'b1; i_dat = 8'h5A; o_ready = 1'b1;
    w_i_valid = 1'b0; w_i_dat = '0; w_o_ready = 1'b0;
    tick(); tick(); tick();
    check_outs("reset_held", 1'b0, 8'h00, 1'b1, 2'd0);
    i_valid = 1'b0;
    reset = 1'b0;
    tick();
    check_outs("reset_release", 1'b0, 8'h00, 1'b1, 2'd0);

    for (int i = 0; i < 10; i++) begin
      i_valid = vecs[i].iv; i_dat = vecs[i].d; o_ready = vecs[i].ordy;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_od, vecs[i].e_ir, vecs[i].e_lv);
    end

    // Streaming at full rate
    o_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      i_valid = 1'b1; i_dat = 8'(k);
      tick();
      check_outs($sformatf("stream%0d", k), 1'b1, 8'(k), 1'b1, 2'd1);
    end
    i_valid = 1'b0;
    tick();
    check_outs("stream_drain", 1'b0, 8'h10, 1'b1, 2'd0);

    // Random stress against a queue model
    accepted = 0; cycles = 0; stalled = 1'b0; prev_dat = '0;
    while (accepted < 2000 && cycles < 20000) begin
      check("rnd level", 32'(level), 32'(sb.size()));
      check("rnd i_ready", 32'(i_ready), 32'(sb.size() != 2));
      check("rnd o_valid", 32'(o_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) check("rnd o_dat", 32'(o_dat), 32'(sb[0]));
      if (stalled) check("rnd stall stable", 32'(o_dat), 32'(prev_dat));
      iv_r = 1'($urandom % 2); or_r = 1'($urandom % 2); d_r = 8'($urandom);
      i_valid = iv_r; i_dat = d_r; o_ready = or_r;
      acc = iv_r && (sb.size() != 2);
      del = or_r && (sb.size() != 0);
      stalled = (sb.size() != 0) && !or_r;
      prev_dat = o_dat;
      tick();
      cycles++;
      if (del) void'(sb.pop_front());
      if (acc) begin sb.push_back(d_r); accepted++; end
    end
    check("rnd beats accepted", 32'(accepted), 32'd2000);
    i_valid = 1'b0; o_ready = 1'b1;
    tick(); tick(); tick();
    check_outs("rnd_drained", 1'b0, o_dat, 1'b1, 2'd0);
    check("rnd o_valid drained", 32'(o_valid), 32'd0);

    // Reset asserted between edges while FULL
    o_ready = 1'b0;
    i_valid = 1'b1; i_dat = 8'h11; tick();
    i_valid = 1'b1; i_dat = 8'h22; tick();
    check_outs("pre_reset_full", 1'b1, 8'h11, 1'b0, 2'd2);
    i_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_outs("async_reset", 1'b0, 8'h00, 1'b1, 2'd0);
    #2 reset = 1'b0;
    o_ready = 1'b1; i_valid = 1'b1; i_dat = 8'h33;
    tick();
    check_outs("post_reset_33", 1'b1, 8'h33, 1'b1, 2'd1);
    i_valid = 1'b0;
    tick();
    check_outs("post_reset_empty", 1'b0, 8'h33, 1'b1, 2'd0);

    // 32-bit payload under backpressure
    w_o_ready = 1'b0; w_i_valid = 1'b1; w_i_dat = 32'hDEADBEEF;
    tick();
    check("w32 first", w_o_dat, 32'hDEADBEEF);
    w_i_dat = 32'h00000001;
    tick();
    check("w32 full level", 32'(w_level), 32'd2);
    check("w32 held", w_o_dat, 32'hDEADBEEF);
    w_i_valid = 1'b0; w_o_ready = 1'b1;
    tick();
    check("w32 second", w_o_dat, 32'h00000001);
    check("w32 level1", 32'(w_level), 32'd1);
    tick();
    check("w32 drained", 32'(w_o_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fw_rv_skid_buffer.md
# fw_rv_skid_buffer

Two-entry ready/valid register slice with every output driven from a flop, including `i_ready`. No combinational path exists from `o_ready` to `i_ready`, or from `i_valid`/`i_dat` to `o_valid`/`o_dat`. It sits between rv components wherever a forward-only register stage still leaves a long `ready` path. It sustains one transfer per clock with one cycle of forward latency.

## Interface
- `WIDTH`, default 8: payload width in bits.
- `clock`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `i_dat`  input  WIDTH  target-side payload.
- `i_valid`  input  1  target-side valid.
- `i_ready`  output  1  target-side ready (registered).
- `o_dat`  output  WIDTH  initiator-side payload (registered).
- `o_valid`  output  1  initiator-side valid (registered).
- `o_ready`  input  1  initiator-side ready.
- `level`  output  2  number of entries held: 0, 1 or 2 (registered).

## Operation
- Storage is a main register (drives `o_dat`) and a skid register. A 3-state FSM controls them:
  - EMPTY: level 0.
  - BUSY: level 1, main holds data.
  - FULL: level 2, main and skid both hold data.
- Transfer rules:
  - An input transfer occurs when `i_valid & i_ready` at a rising edge.
  - An output transfer occurs when `o_valid & o_ready` at a rising edge.
- Derived outputs, all decoded into flops with the next state:
  - `o_valid` = state != EMPTY.
  - `i_ready` = state != FULL.
  - `level` = 0, 1 or 2 per the state definitions above.
- EMPTY:
  - `i_valid` → BUSY, main <= `i_dat`.
  - Otherwise stay in EMPTY.
- BUSY:
  - `i_valid & o_ready` → stay in BUSY, main <= `i_dat` (pass-through at full rate).
  - `i_valid & !o_ready` → FULL, skid <= `i_dat`. Main is unchanged.
  - `!i_valid & o_ready` → EMPTY.
  - `!i_valid & !o_ready` → stay in BUSY, hold.
- FULL:
  - `i_ready` = 0, so `i_valid` is ignored.
  - `o_ready` → BUSY, main <= skid.
  - Otherwise stay in FULL, hold.
- Ordering: data leaves in arrival order. No beat is dropped or duplicated.
- While `o_valid` = 1 and `o_ready` = 0, `o_dat` is stable.
- Reset (asserted asynchronously, at any time including mid-transfer):
  - State → EMPTY; main and skid → 0.
  - `o_valid` = 0, `o_dat` = 0, `i_ready` = 1, `level` = 0.
  - Buffered data is discarded.
  - No transfer is recognised on an edge where `reset` is high.

## Timing
- Forward latency: a beat accepted at edge N is on `o_dat` with `o_valid` = 1 after edge N, so it can be consumed at edge N+1.
- Backpressure latency: `o_ready` falling at edge N can still let one further beat in at edge N; `i_ready` falls after edge N. That beat lands in skid.
- Recovery: in FULL, `o_ready` = 1 at edge N → `i_ready` = 1 after edge N.
- Throughput: 1 beat/cycle whenever `o_ready` is held high.
- Simultaneous input and output transfer in BUSY keeps `level` at 1.
- There is no combinational input-to-output path. All outputs change only on `clock` edges or on `reset` assertion.

## Test plan
- **Reset values:** reset high, then deassert → `o_valid` = 0, `i_ready` = 1, `level` = 0, `o_dat` = 0. Also drive `i_valid` = 1 with `i_dat` = 0x5A while reset is high → nothing is captured and `o_valid` stays 0.
- **Streaming:** `o_ready` held 1; send 0x01..0x10 on consecutive cycles → identical sequence on `o_dat`, each beat one cycle later. `i_ready` never drops and `level` stays ≤ 1.
- **Skid fill and drain:**
  - Send 0xA1; lower `o_ready` the cycle 0xA2 is presented.
  - Required: 0xA2 is accepted, `level` = 2, `i_ready` = 0 next cycle, `o_dat` holds 0xA1, 0xA3 is held off.
  - Raise `o_ready` → 0xA1, 0xA2, 0xA3 out in order, and `i_ready` returns to 1 one cycle after `o_ready` rises.
- **Random stress:** 2000 beats with random `i_valid`/`o_ready` (50%) → scoreboard matches exactly. Check:
  - `o_dat` stable while stalled;
  - `level` equals (accepted − delivered);
  - `i_ready` = 0 iff `level` = 2.
- **Reset mid-operation:** reach FULL with 0x11 and 0x22, assert reset asynchronously between edges → outputs immediately show `o_valid` = 0, `level` = 0, `i_ready` = 1. After release, 0x33 passes alone.
- **Width check:** with WIDTH = 32, stream 0xDEADBEEF and 0x00000001 under backpressure → values are preserved exactly.
